// File: rtl/eqn_chunk_cmp_if.sv
`default_nettype none
// ============================================================================
//  Module      : eqn_chunk_cmp_if
//  Description : Start/operand/result bundle for the chunked magnitude comparator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface eqn_chunk_cmp_if #(
    parameter int W = 16
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         signed_mode;
    logic         ready;
    logic         done;
    logic         aeqb;
    logic         agtb;
    logic         altb;

    modport master (
        output start, a, b, signed_mode,
        input  ready, done, aeqb, agtb, altb
    );

    modport slave (
        input  start, a, b, signed_mode,
        output ready, done, aeqb, agtb, altb
    );
endinterface
`default_nettype wire

// File: rtl/eqn_chunk_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : eqn_chunk_cmp
//  Description : Multi-cycle W-bit eq/gt/lt comparator, C bits per cycle, MSB
//                chunk first with early exit; unsigned or two's complement.
//  Revision    : 1.0 - initial release
// ============================================================================
module eqn_chunk_cmp #(
    parameter int W = 16,
    parameter int C = 4
) (
    input  logic               clk,
    input  logic               reset,
    eqn_chunk_cmp_if.slave     bus
);

    localparam int c_NCH = W / C;
    localparam int c_KW  = (c_NCH > 1) ? $clog2(c_NCH) : 1;
    localparam logic [C-1:0]    c_MSB  = C'(1) << (C - 1);
    localparam logic [c_KW-1:0] c_LAST = c_KW'(c_NCH - 1);

    generate
        if ((C < 1) || (C > W) || ((W % C) != 0)) begin : g_bad_param
            $error("eqn_chunk_cmp: W must be a positive multiple of C");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_sm;
    logic [c_KW-1:0] r_k;
    logic            r_eq;
    logic            r_gt;
    logic            r_lt;

    logic [W-1:0]    w_a_sh;
    logic [W-1:0]    w_b_sh;
    logic [C-1:0]    w_ca;
    logic [C-1:0]    w_cb;
    logic            w_flip;
    logic            w_last;
    logic            w_gt;
    logic            w_lt;
    logic            w_accept;

    // Operands are shifted left as chunks are consumed, so the chunk under
    // test always sits in the top C bits.
    generate
        if (C < W) begin : g_shift
            assign w_a_sh = {r_a[W-C-1:0], {C{1'b0}}};
            assign w_b_sh = {r_b[W-C-1:0], {C{1'b0}}};
        end else begin : g_noshift
            assign w_a_sh = r_a;
            assign w_b_sh = r_b;
        end
    endgenerate

    // Inverting the sign bit of the top chunk maps two's complement order
    // onto unsigned order; lower chunks are plain magnitude bits.
    assign w_flip   = r_sm && (r_k == '0);
    assign w_ca     = r_a[W-1 -: C] ^ (w_flip ? c_MSB : '0);
    assign w_cb     = r_b[W-1 -: C] ^ (w_flip ? c_MSB : '0);
    assign w_gt     = (w_ca > w_cb);
    assign w_lt     = (w_ca < w_cb);
    assign w_last   = (r_k == c_LAST);
    assign w_accept = (r_state == S_IDLE) && bus.start;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_next = S_CMP;
            S_CMP:  if (w_gt || w_lt || w_last) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_k  <= '0;
                r_eq <= 1'b0;
                r_gt <= 1'b0;
                r_lt <= 1'b0;
            end else if (r_state == S_CMP) begin
                if (w_gt) begin
                    r_gt <= 1'b1;
                end else if (w_lt) begin
                    r_lt <= 1'b1;
                end else if (w_last) begin
                    r_eq <= 1'b1;
                end else begin
                    r_k <= r_k + 1'b1;
                end
            end
        end
    end

    // Operand registers carry no reset; their content is meaningless outside CMP.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a  <= bus.a;
            r_b  <= bus.b;
            r_sm <= bus.signed_mode;
        end else if ((r_state == S_CMP) && !w_gt && !w_lt && !w_last) begin
            r_a  <= w_a_sh;
            r_b  <= w_b_sh;
        end
    end

    assign bus.ready = (r_state == S_IDLE);
    assign bus.done  = (r_state == S_DONE);
    assign bus.aeqb  = r_eq;
    assign bus.agtb  = r_gt;
    assign bus.altb  = r_lt;

endmodule
`default_nettype wire

// File: tb/tb_eqn_chunk_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eqn_chunk_cmp
//  Description : Scoreboard bench: directed cases on a 16/4 instance plus random
//                operand pairs on 16/4, 16/16, 8/1 and 32/8 instances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eqn_chunk_cmp;

    localparam int c_NRAND = 4000;
    localparam int c_CW[4] = '{16, 16, 8, 32};
    localparam int c_CC[4] = '{4, 16, 1, 8};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit          directed_done = 1'b0;
    bit [3:0]    rand_done = '0;
    int          main_dones = 0;

    typedef struct {
        logic [2:0]  flags;
        int unsigned cyc;
        string       tag;
    } exp_t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference flags {aeqb, agtb, altb} via sign-extended integer compare.
    function automatic logic [2:0] ref_flags(input logic [31:0] a, input logic [31:0] b,
                                             input int w, input bit sm);
        longint sa, sb;
        sa = longint'(a);
        sb = longint'(b);
        if (sm && a[w-1]) sa = sa - (longint'(1) << w);
        if (sm && b[w-1]) sb = sb - (longint'(1) << w);
        if (sa == sb) return 3'b100;
        if (sa > sb)  return 3'b010;
        return 3'b001;
    endfunction

    function automatic int first_diff(input logic [31:0] a, input logic [31:0] b,
                                      input int w, input int c);
        longint mask;
        mask = (longint'(1) << c) - 1;
        for (int j = 0; j < w / c; j++) begin
            if ((((longint'(a) ^ longint'(b)) >> (w - (j + 1) * c)) & mask) != 0) return j;
        end
        return w / c - 1;
    endfunction

    // ---------------- directed instance (W=16, C=4) ----------------
    eqn_chunk_cmp_if #(.W(16)) mbus ();
    eqn_chunk_cmp #(.W(16), .C(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mbus.slave)
    );

    exp_t mq[$];

    always @(negedge clk) begin
        exp_t e;
        if (mbus.done) begin
            main_dones++;
            if (mq.size() == 0) begin
                check("main_spurious_done", 1, 0);
            end else begin
                e = mq.pop_front();
                check({e.tag, "_flags"}, {mbus.aeqb, mbus.agtb, mbus.altb}, e.flags);
                check({e.tag, "_lat"}, cyc, e.cyc);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    // done is sampled with cyc = accept + j + 1, i.e. in cycle t + j + 2.
    task automatic main_start(input logic [15:0] a, input logic [15:0] b,
                              input bit sm, input string tag);
        int n = 0;
        while (!mbus.ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_ready"}, mbus.ready, 1);
        mbus.start = 1'b1;
        mbus.a = a;
        mbus.b = b;
        mbus.signed_mode = sm;
        @(posedge clk); #1;
        mbus.start = 1'b0;
        mq.push_back('{ref_flags(32'(a), 32'(b), 16, sm),
                       cyc + first_diff(32'(a), 32'(b), 16, 4) + 1, tag});
    endtask

    task automatic main_wait(input string tag);
        int n = 0;
        while (mq.size() != 0 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_timeout"}, mq.size(), 0);
    endtask

    initial begin
        int n;
        mbus.start = 1'b0;
        mbus.a = '0;
        mbus.b = '0;
        mbus.signed_mode = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", mbus.ready, 1);
        check("rst_done", mbus.done, 0);
        check("rst_flags", {mbus.aeqb, mbus.agtb, mbus.altb}, 3'b000);
        @(posedge clk); #1;
        reset = 1'b0;

        main_start(16'hA5A5, 16'hA5A5, 1'b0, "eq_a5a5");
        check("busy_ready", mbus.ready, 0);
        check("busy_flags", {mbus.aeqb, mbus.agtb, mbus.altb}, 3'b000);
        main_wait("eq_a5a5");
        check("eq_ready_back", mbus.ready, 1);
        check("eq_hold_flags", {mbus.aeqb, mbus.agtb, mbus.altb}, 3'b100);

        main_start(16'h8000, 16'h7FFF, 1'b0, "u_8000");
        main_wait("u_8000");
        main_start(16'h8000, 16'h7FFF, 1'b1, "s_8000");
        main_wait("s_8000");
        main_start(16'h1234, 16'h1235, 1'b0, "u_1234");
        main_wait("u_1234");
        main_start(16'hFFFE, 16'hFFFF, 1'b1, "s_fffe");
        main_wait("s_fffe");

        // Starts while busy must be ignored; the one left high into IDLE is taken.
        main_start(16'h00F0, 16'h00F0, 1'b0, "ign_00f0");
        n = 0;
        while (mq.size() != 0 && n < 40) begin
            mbus.start = 1'b1;
            mbus.a = 16'hFFFF;
            mbus.b = 16'h0000;
            mbus.signed_mode = 1'b0;
            @(posedge clk); #1; n++;
        end
        check("ign_timeout", mq.size(), 0);
        check("ign_idle_ready", mbus.ready, 1);
        check("ign_idle_flags", {mbus.aeqb, mbus.agtb, mbus.altb}, 3'b100);
        @(posedge clk); #1;
        mbus.start = 1'b0;
        mq.push_back('{3'b010, cyc + 1, "ign_next"});
        check("ign_next_cleared", {mbus.aeqb, mbus.agtb, mbus.altb}, 3'b000);
        main_wait("ign_next");

        // Reset in the second CMP cycle aborts without a done pulse.
        main_start(16'h1234, 16'h1234, 1'b0, "rst_abort");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mq.delete();
        n = main_dones;
        check("abort_ready", mbus.ready, 1);
        check("abort_done", mbus.done, 0);
        check("abort_flags", {mbus.aeqb, mbus.agtb, mbus.altb}, 3'b000);
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_done", main_dones, n);
        main_start(16'd3, 16'd5, 1'b0, "post_rst");
        main_wait("post_rst");

        directed_done = 1'b1;
        n = 0;
        while (rand_done != 4'hF && n < 60000) begin
            @(posedge clk); n++;
        end
        check("rand_finish", rand_done, 4'hF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- random regression instances ----------------
    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int GW  = c_CW[g];
        localparam int GC  = c_CC[g];
        localparam int GNC = GW / GC;

        eqn_chunk_cmp_if #(.W(GW)) rbus ();
        eqn_chunk_cmp #(.W(GW), .C(GC)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (rbus.slave)
        );

        exp_t q[$];

        always @(negedge clk) begin
            exp_t e;
            if (rbus.done) begin
                if (q.size() == 0) begin
                    check($sformatf("rnd%0d_spurious_done", g), 1, 0);
                end else begin
                    e = q.pop_front();
                    check({e.tag, "_flags"}, {rbus.aeqb, rbus.agtb, rbus.altb}, e.flags);
                    check({e.tag, "_lat"}, cyc, e.cyc);
                end
            end
        end

        initial begin
            logic [GW-1:0] ra, rb;
            bit            sm;
            int            sel, j, n;
            longint        nz;
            rbus.start = 1'b0;
            rbus.a = '0;
            rbus.b = '0;
            rbus.signed_mode = 1'b0;
            wait (directed_done);
            @(posedge clk); #1;
            for (int i = 0; i < c_NRAND; i++) begin
                ra  = GW'($urandom);
                sm  = 1'($urandom);
                sel = $urandom_range(3);
                if (sel == 0) begin
                    rb = ra;
                end else if (sel == 3) begin
                    rb = GW'($urandom);
                end else begin
                    j  = $urandom_range(GNC - 1);
                    nz = longint'($urandom_range((1 << GC) - 1, 1));
                    rb = ra ^ GW'(nz << (GW - (j + 1) * GC));
                end
                n = 0;
                while (!rbus.ready && n < 40) begin
                    @(posedge clk); #1; n++;
                end
                rbus.start = 1'b1;
                rbus.a = ra;
                rbus.b = rb;
                rbus.signed_mode = sm;
                @(posedge clk); #1;
                rbus.start = 1'b0;
                q.push_back('{ref_flags(32'(ra), 32'(rb), GW, sm),
                              cyc + first_diff(32'(ra), 32'(rb), GW, GC) + 1,
                              $sformatf("rnd%0d_%0d", g, i)});
                n = 0;
                while (q.size() != 0 && n < 60) begin
                    @(posedge clk); #1; n++;
                end
                if (q.size() != 0) begin
                    check($sformatf("rnd%0d_%0d_timeout", g, i), q.size(), 0);
                    q.delete();
                end
            end
            rand_done[g] = 1'b1;
        end
    end

endmodule
`default_nettype wire
